// File: rtl/spi_regfile.sv
// -----------------------------------------------------------------------------
// spi_regfile
//
// Register bank sitting directly behind spi_frontend. The frontend decodes
// each frame into is_write/addr/wdata; this block tracks the same frame
// bit/byte position on its own, commits write bytes into NUM_REGS 8-bit
// control registers and serialises read data back to the host on poci.
// Everything runs in the spi_clk domain.
//
// Ports
//   spi_clk    in   SPI clock, all state updates on the rising edge
//   rstn       in   asynchronous active-low reset
//   cs         in   chip select, active low; high clears frame state at once
//   is_write   in   current frame is a write
//   addr       in   current target address (7 bits)
//   wdata      in   current data byte, complete at in-byte bit index 7
//   status_in  in   core status, readable at STATUS_ADDR
//   poci       out  serial read data, MSB first
//   regs_out   out  flattened register contents, reg k at [8k+7:8k]
//   wr_pulse   out  one-cycle strobe after each committed write
//   wr_addr    out  address of the last committed write
// -----------------------------------------------------------------------------
module spi_regfile #(
    parameter int         NUM_REGS    = 16,
    parameter logic [7:0] RESET_VAL   = 8'h00,
    parameter logic [6:0] STATUS_ADDR = 7'h7F
) (
    input  logic                  spi_clk,
    input  logic                  rstn,
    input  logic                  cs,
    input  logic                  is_write,
    input  logic [6:0]            addr,
    input  logic [7:0]            wdata,
    input  logic [7:0]            status_in,
    output logic                  poci,
    output logic [8*NUM_REGS-1:0] regs_out,
    output logic                  wr_pulse,
    output logic [6:0]            wr_addr
);

    typedef enum logic {
        PH_CMD  = 1'b0,
        PH_DATA = 1'b1
    } phase_e;

    localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

    // Frame-tracking state (cleared by reset or by cs going high)
    logic [2:0] bit_cnt_q, bit_cnt_d;
    phase_e     phase_q,   phase_d;
    logic [7:0] shift_q,   shift_d;
    logic       wr_pulse_q, wr_pulse_d;

    // Persistent state (cleared by reset only)
    logic [6:0] rd_ptr_q,  rd_ptr_d;
    logic [6:0] wr_addr_q;
    logic [7:0] regs_q [NUM_REGS];

    logic       frame_clr_n;
    logic       byte_end;
    logic       addr_in_range;
    logic       commit;
    logic [6:0] rd_sel;
    logic [7:0] rd_data;

    // The frame logic is cleared whenever the host deselects us, so a frame
    // aborted mid-byte can never leave a half-counted byte behind.
    assign frame_clr_n = rstn & ~cs;

    assign byte_end      = (bit_cnt_q == 3'd7);
    assign addr_in_range = ({1'b0, addr} < NUM_REGS_W);

    // cs is part of the commit term so an edge coincident with deselect
    // never writes, independent of how the async clear resolves.
    assign commit = ~cs & (phase_q == PH_DATA) & byte_end & is_write & addr_in_range;

    // Read source: the command byte's address for the first data byte, the
    // auto-incremented pointer for every byte after that.
    assign rd_sel = (phase_q == PH_CMD) ? addr : rd_ptr_q;

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no
        // path through the block leaves it unassigned and no latch is inferred.
        rd_data = 8'h00;
        if ({1'b0, rd_sel} < NUM_REGS_W) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (rd_sel == 7'(k)) begin
                    rd_data = regs_q[k];
                end
            end
        end else if (rd_sel == STATUS_ADDR) begin
            rd_data = status_in;
        end
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q + 3'd1;   // wraps 7 -> 0
        phase_d    = byte_end ? PH_DATA : phase_q;
        wr_pulse_d = commit;
        shift_d    = shift_q;
        rd_ptr_d   = rd_ptr_q;

        if (!cs && !is_write) begin
            if (byte_end) begin
                // Byte boundary: load the next read byte. status_in is only
                // sampled here, so it cannot change on poci mid-byte.
                shift_d = rd_data;
                if (phase_q == PH_CMD) begin
                    rd_ptr_d = addr + 7'd1;
                end else begin
                    rd_ptr_d = rd_ptr_q + 7'd1;
                end
            end else if (phase_q == PH_DATA) begin
                shift_d = {shift_q[6:0], 1'b0};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge spi_clk or negedge frame_clr_n) begin
        if (!frame_clr_n) begin
            bit_cnt_q  <= 3'd0;
            phase_q    <= PH_CMD;
            shift_q    <= 8'h00;
            wr_pulse_q <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            phase_q    <= phase_d;
            shift_q    <= shift_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // NOTE: the register array is reset on purpose: these are control
    // registers the core acts on, so they must hold RESET_VAL after rstn.
    always_ff @(posedge spi_clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VAL;
            end
            wr_addr_q <= 7'd0;
            rd_ptr_q  <= 7'd0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (commit && (addr == 7'(k))) begin
                    regs_q[k] <= wdata;
                end
            end
            if (commit) begin
                wr_addr_q <= addr;
            end
            rd_ptr_q <= rd_ptr_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[8*g +: 8] = regs_q[g];
    end

    // Read data only drives the line during a selected read frame.
    assign poci     = shift_q[7] & ~cs & ~is_write;
    assign wr_pulse = wr_pulse_q;
    assign wr_addr  = wr_addr_q;

endmodule

// File: tb/tb_spi_regfile.sv
// -----------------------------------------------------------------------------
// tb_spi_regfile
//
// Drives spi_regfile the way spi_frontend would (decoded is_write/addr/wdata
// held across the frame) using directed frames. Expected write commits and
// read bytes are queued when each frame is issued; a monitor process pops
// them when the DUT strobes wr_pulse or finishes shifting a read byte.
// -----------------------------------------------------------------------------
module tb_spi_regfile;

    localparam int NREGS = 16;

    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
    } wr_exp_t;

    logic                 clk;
    logic                 rstn;
    logic                 cs;
    logic                 is_write;
    logic [6:0]           addr;
    logic [7:0]           wdata;
    logic [7:0]           status_in;
    logic                 poci;
    logic [8*NREGS-1:0]   regs_out;
    logic                 wr_pulse;
    logic [6:0]           wr_addr;

    int          n_cmp = 0;
    int          n_bad = 0;
    wr_exp_t     exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  model [NREGS];
    logic [6:0]  last_wr_addr;
    logic        rd_window;

    spi_regfile #(
        .NUM_REGS    (NREGS),
        .RESET_VAL   (8'h00),
        .STATUS_ADDR (7'h7F)
    ) dut (
        .spi_clk   (clk),
        .rstn      (rstn),
        .cs        (cs),
        .is_write  (is_write),
        .addr      (addr),
        .wdata     (wdata),
        .status_in (status_in),
        .poci      (poci),
        .regs_out  (regs_out),
        .wr_pulse  (wr_pulse),
        .wr_addr   (wr_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < NREGS; k++) begin
            check($sformatf("%s reg%0d", tag, k), {24'b0, regs_out[8*k +: 8]}, {24'b0, model[k]});
        end
    endtask

    // One frame: 8 command edges, then nbytes data bytes. abort_bits >= 0
    // raises cs after that many data edges. status_mid >= 0 changes
    // status_in partway through the first data byte.
    task automatic run_frame(input logic wr, input logic [6:0] a, input int nbytes,
                             input logic [7:0] b0, input logic [7:0] b1,
                             input int abort_bits, input int status_mid);
        logic [7:0] bytes_v [2];
        logic       stop;
        bytes_v[0] = b0;
        bytes_v[1] = b1;
        stop = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        cs       = 1'b0;
        is_write = wr;
        addr     = a;
        wdata    = 8'h00;
        repeat (8) @(posedge clk);
        #2;
        if (!wr) rd_window = 1'b1;
        for (int k = 0; k < nbytes && !stop; k++) begin
            wdata = bytes_v[k];
            if (wr && a < 7'(NREGS) && (abort_bits < 0 || abort_bits >= (k + 1) * 8)) begin
                exp_wr.push_back('{a: a, d: bytes_v[k]});
                model[a[3:0]] = bytes_v[k];
                last_wr_addr  = a;
            end
            for (int b = 0; b < 8; b++) begin
                if (abort_bits == k * 8 + b) begin
                    stop = 1'b1;
                    break;
                end
                if (k == 0 && b == 3 && status_mid >= 0) status_in = 8'(status_mid);
                @(posedge clk);
                #2;
            end
        end
        rd_window = 1'b0;
        @(negedge clk);
        #1;
        cs       = 1'b1;
        is_write = 1'b0;
    endtask

    // Monitor: pops a queued expectation for every wr_pulse cycle and every
    // completed read byte.
    initial begin
        logic [7:0] cap;
        int         nb;
        wr_exp_t    e;
        logic [7:0] er;
        cap = 8'h00;
        nb  = 0;
        forever begin
            @(negedge clk);
            if (wr_pulse === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    check("wr_pulse unexpected", {31'b0, wr_pulse}, 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    check($sformatf("wr_addr on pulse @%0h", e.a), {25'b0, wr_addr}, {25'b0, e.a});
                    check($sformatf("reg after commit @%0h", e.a),
                          {24'b0, regs_out[8*int'(e.a) +: 8]}, {24'b0, e.d});
                end
            end
            if (rd_window) begin
                cap = {cap[6:0], poci};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (exp_rd.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL read byte unexpected: got 0x%0h required none", cap);
                    end else begin
                        er = exp_rd.pop_front();
                        check("read byte", {24'b0, cap}, {24'b0, er});
                    end
                end
            end else begin
                nb = 0;
            end
        end
    end

    initial begin
        rstn         = 1'b0;
        cs           = 1'b1;
        is_write     = 1'b0;
        addr         = 7'd0;
        wdata        = 8'h00;
        status_in    = 8'h00;
        rd_window    = 1'b0;
        last_wr_addr = 7'd0;
        for (int k = 0; k < NREGS; k++) model[k] = 8'h00;

        #12;
        check("reset wr_pulse", {31'b0, wr_pulse}, 32'd0);
        check("reset wr_addr", {25'b0, wr_addr}, 32'd0);
        check("reset poci", {31'b0, poci}, 32'd0);
        check_regs("reset");
        #10;
        rstn = 1'b1;

        // Single in-range write
        run_frame(1'b1, 7'h03, 1, 8'hA5, 8'h00, -1, -1);
        check_regs("after wr3");
        check("wr_addr after wr3", {25'b0, wr_addr}, {25'b0, last_wr_addr});

        // Out-of-range writes, including the status address: dropped
        run_frame(1'b1, 7'h20, 1, 8'hFF, 8'h00, -1, -1);
        run_frame(1'b1, 7'h7F, 1, 8'hFF, 8'h00, -1, -1);
        check_regs("after oor");
        check("wr_addr holds after oor", {25'b0, wr_addr}, 32'h03);

        // Setup writes, plus a two-byte write committing twice at one address
        run_frame(1'b1, 7'h05, 1, 8'h3C, 8'h00, -1, -1);
        run_frame(1'b1, 7'h06, 1, 8'hC3, 8'h00, -1, -1);
        run_frame(1'b1, 7'h00, 1, 8'h81, 8'h00, -1, -1);
        run_frame(1'b1, 7'h0F, 1, 8'hE7, 8'h00, -1, -1);
        run_frame(1'b1, 7'h09, 2, 8'h11, 8'h22, -1, -1);
        check_regs("after setup");
        check("wr_addr after multi", {25'b0, wr_addr}, 32'h09);

        // Read with auto-increment
        exp_rd.push_back(8'h3C);
        exp_rd.push_back(8'hC3);
        run_frame(1'b0, 7'h05, 2, 8'h00, 8'h00, -1, -1);

        // Status read, changed mid-byte, then pointer wraps to reg0
        status_in = 8'h5A;
        exp_rd.push_back(8'h5A);
        exp_rd.push_back(8'h81);
        run_frame(1'b0, 7'h7F, 2, 8'h00, 8'h00, -1, 8'h00);

        // Last register followed by an unmapped address
        exp_rd.push_back(8'hE7);
        exp_rd.push_back(8'h00);
        run_frame(1'b0, 7'h0F, 2, 8'h00, 8'h00, -1, -1);

        // Aborted write after 4 data bits: nothing commits
        run_frame(1'b1, 7'h02, 1, 8'h77, 8'h00, 4, -1);
        check_regs("after abort");
        check("wr_addr after abort", {25'b0, wr_addr}, 32'h09);
        // Following frames must be byte-aligned from a clean CMD start
        exp_rd.push_back(8'h3C);
        exp_rd.push_back(8'hC3);
        run_frame(1'b0, 7'h05, 2, 8'h00, 8'h00, -1, -1);
        run_frame(1'b1, 7'h02, 1, 8'h4B, 8'h00, -1, -1);
        check_regs("after post-abort write");

        // Reset asserted mid read frame (reg3 = A5 = 1010_0101)
        repeat (2) @(posedge clk);
        #2;
        cs       = 1'b0;
        is_write = 1'b0;
        addr     = 7'h03;
        repeat (8) @(posedge clk);
        #2;
        check("poci read bit7", {31'b0, poci}, 32'd1);
        @(posedge clk);
        #2;
        check("poci read bit6", {31'b0, poci}, 32'd0);
        @(posedge clk);
        #2;
        check("poci read bit5", {31'b0, poci}, 32'd1);
        rstn = 1'b0;
        #1;
        for (int k = 0; k < NREGS; k++) model[k] = 8'h00;
        check("midframe reset poci", {31'b0, poci}, 32'd0);
        check("midframe reset wr_pulse", {31'b0, wr_pulse}, 32'd0);
        check("midframe reset wr_addr", {25'b0, wr_addr}, 32'd0);
        check_regs("midframe reset");
        #2;
        cs = 1'b1;
        #5;
        rstn = 1'b1;
        repeat (3) @(posedge clk);

        check("write queue drained", exp_wr.size(), 32'd0);
        check("read queue drained", exp_rd.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
